cam_emulator: RTL and testbench

Synthesizable OV7670-style pixel-stream transmitter: generates the PCLK/VSYNC/HREF/D[7:0] waveforms that the camera capture block consumes and drives them with a selectable RGB565 test pattern. It replaces the physical camera on the board or in simulation, so the capture → dual-port RAM → VGA path can be checked end to end against known pixel values.

---
 rtl/cam_emu_pkg.sv | 40 ++++
 rtl/cam_emulator_if.sv | 10 +
 rtl/cam_pattern_gen.sv | 40 ++++
 rtl/cam_emulator.sv | 212 +++++++++++++++++++++
 tb/tb_cam_emulator.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_emu_pkg.sv
// Shared types and constants for the OV7670-style camera emulator.
// Holds the FSM state encoding, pattern codes and the colour-bar palette.
package cam_emu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_HBLANK,
    S_VFRONT
  } cam_state_t;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_SOLID = 2'd1;
  localparam logic [1:0] PAT_COORD = 2'd2;
  localparam logic [1:0] PAT_GRAD  = 2'd3;

  // Bars run left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    c = 16'h0000;
    case (idx)
      3'd0: c = 16'hFFFF;
      3'd1: c = 16'hFFE0;
      3'd2: c = 16'h07FF;
      3'd3: c = 16'h07E0;
      3'd4: c = 16'hF81F;
      3'd5: c = 16'hF800;
      3'd6: c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cam_emulator_if.sv
// Camera-side pixel bus: the waveforms a real OV7670 would drive.
interface cam_emulator_if;
  logic       cam_pclk;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_d;

  modport master (output cam_pclk, output cam_vsync, output cam_href, output cam_d);
  modport slave  (input  cam_pclk, input  cam_vsync, input  cam_href, input  cam_d);
endinterface

// File: rtl/cam_pattern_gen.sv
// Combinational RGB565 test-pattern source: maps pixel (x, y) and the
// latched pattern selection to one 16-bit pixel.
module cam_pattern_gen
  import cam_emu_pkg::*;
#(
  parameter int H_PIXELS = 160,
  parameter int XW       = 8,
  parameter int YW       = 7
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [1:0]    pattern,
  input  logic [15:0]   solid_rgb,
  output logic [15:0]   pixel
);

  localparam int BAR_W = H_PIXELS / 8;

  logic [2:0] bar_idx;
  logic [7:0] x8;
  logic [7:0] y8;

  always_comb begin
    x8      = 8'(x);
    y8      = 8'(y);
    pixel   = 16'h0000;
    // Threshold compare instead of a divider: BAR_W need not be a power of two.
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (int'(x) >= i * BAR_W) bar_idx = 3'(i);
    end
    case (pattern)
      PAT_BARS:  pixel = bar_color(bar_idx);
      PAT_SOLID: pixel = solid_rgb;
      PAT_COORD: pixel = {y8, x8};
      default:   pixel = {x8[4:0], x8[5:0], x8[4:0]};
    endcase
  end

endmodule

// File: rtl/cam_emulator.sv
// OV7670-style transmitter: produces PCLK/VSYNC/HREF/D for one frame per
// enable, carrying a selectable RGB565 test pattern, high byte first.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for enable; latches pattern/solid_rgb on exit
// S_VSYNC  | cam_vsync high for VSYNC_PCLKS
// S_VBACK  | back porch before the first line
// S_ACTIVE | cam_href high, two bytes per pixel
// S_HBLANK | line blanking, cam_d forced to zero
// S_VFRONT | front porch; exit pulses frame_done and drops busy
module cam_emulator
  import cam_emu_pkg::*;
#(
  parameter int H_PIXELS     = 160,
  parameter int V_LINES      = 120,
  parameter int H_BLANK      = 16,
  parameter int VSYNC_PCLKS  = 1008,
  parameter int VBACK_PCLKS  = 2688,
  parameter int VFRONT_PCLKS = 336
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            pattern,
  input  logic [15:0]           solid_rgb,
  cam_emulator_if.master        cam,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int XW        = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW        = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int MAX_BLANK = max_int(max_int(H_BLANK, VSYNC_PCLKS),
                                     max_int(VBACK_PCLKS, VFRONT_PCLKS));
  localparam int CW        = $clog2(MAX_BLANK + 1);

  localparam logic [XW-1:0] X_LAST      = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(V_LINES - 1);
  localparam logic [CW-1:0] LD_VSYNC    = CW'(VSYNC_PCLKS - 1);
  localparam logic [CW-1:0] LD_VBACK    = CW'(VBACK_PCLKS - 1);
  localparam logic [CW-1:0] LD_HBLANK   = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] LD_VFRONT   = CW'(VFRONT_PCLKS - 1);

  cam_state_t      state_q, state_d;
  logic            ph_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            lo_q, lo_d;
  logic [1:0]      pat_q, pat_d;
  logic [15:0]     solid_q, solid_d;
  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic [7:0]      d_q, d_d;
  logic            busy_q, busy_d;
  logic            fd_q, fd_d;
  logic            tc;
  logic [15:0]     pixel;

  assign tc = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    lo_d    = lo_q;
    pat_d   = pat_q;
    solid_d = solid_q;
    vsync_d = vsync_q;
    href_d  = 1'b0;
    busy_d  = busy_q;
    fd_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_VSYNC;
          pat_d   = pattern;
          solid_d = solid_rgb;
          busy_d  = 1'b1;
          vsync_d = 1'b1;
          cnt_d   = LD_VSYNC;
        end
      end
      S_VSYNC: begin
        if (tc) begin
          state_d = S_VBACK;
          vsync_d = 1'b0;
          cnt_d   = LD_VBACK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_VBACK: begin
        if (tc) begin
          state_d = S_ACTIVE;
          href_d  = 1'b1;
          x_d     = '0;
          y_d     = '0;
          lo_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ACTIVE: begin
        href_d = 1'b1;
        if (!lo_q) begin
          lo_d = 1'b1;
        end else if (x_q == X_LAST) begin
          state_d = S_HBLANK;
          href_d  = 1'b0;
          lo_d    = 1'b0;
          x_d     = '0;
          cnt_d   = LD_HBLANK;
        end else begin
          x_d  = x_q + XW'(1);
          lo_d = 1'b0;
        end
      end
      S_HBLANK: begin
        if (!tc) begin
          cnt_d = cnt_q - CW'(1);
        end else if (y_q == Y_LAST) begin
          state_d = S_VFRONT;
          y_d     = '0;
          cnt_d   = LD_VFRONT;
        end else begin
          state_d = S_ACTIVE;
          href_d  = 1'b1;
          y_d     = y_q + YW'(1);
          x_d     = '0;
          lo_d    = 1'b0;
        end
      end
      S_VFRONT: begin
        if (tc) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          fd_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pixel is looked up at the coordinate about to be driven, so the byte
  // can be registered on the same edge as href.
  cam_pattern_gen #(
    .H_PIXELS (H_PIXELS),
    .XW       (XW),
    .YW       (YW)
  ) u_pattern_gen (
    .x         (x_d),
    .y         (y_d),
    .pattern   (pat_q),
    .solid_rgb (solid_q),
    .pixel     (pixel)
  );

  always_comb begin
    d_d = 8'h00;
    if (href_d) d_d = lo_d ? pixel[7:0] : pixel[15:8];
  end

  // Everything advances only when ph is high, so outputs move as PCLK falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ph_q    <= 1'b0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      lo_q    <= 1'b0;
      pat_q   <= 2'd0;
      solid_q <= 16'h0000;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      d_q     <= 8'h00;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      ph_q <= ~ph_q;
      fd_q <= 1'b0;
      if (ph_q) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        x_q     <= x_d;
        y_q     <= y_d;
        lo_q    <= lo_d;
        pat_q   <= pat_d;
        solid_q <= solid_d;
        vsync_q <= vsync_d;
        href_q  <= href_d;
        d_q     <= d_d;
        busy_q  <= busy_d;
        fd_q    <= fd_d;
      end
    end
  end

  assign cam.cam_pclk  = ph_q;
  assign cam.cam_vsync = vsync_q;
  assign cam.cam_href  = href_q;
  assign cam.cam_d     = d_q;
  assign frame_done    = fd_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_cam_emulator.sv
// Bench for cam_emulator: frames compared PCLK by PCLK with a timing/pixel
// model, spot pixel table, enable drop, async reset and PCLK-edge stability.
module tb_cam_emulator;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int HB = 4;
  localparam int VS = 6;
  localparam int VB = 4;
  localparam int VF = 2;
  localparam int LINE_P  = 2 * H + HB;
  localparam int FRAME_S = VS + VB + V * LINE_P + VF;
  localparam int NSLOT   = 4;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [1:0]  pattern;
  logic [15:0] solid_rgb;
  logic        frame_done;
  logic        busy;

  cam_emulator_if cam_bus ();

  cam_emulator #(
    .H_PIXELS     (H),
    .V_LINES      (V),
    .H_BLANK      (HB),
    .VSYNC_PCLKS  (VS),
    .VBACK_PCLKS  (VB),
    .VFRONT_PCLKS (VF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pattern    (pattern),
    .solid_rgb  (solid_rgb),
    .cam        (cam_bus),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad < 60) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: frame timing and pixel colours from plain arithmetic.
  logic [15:0] bar_tbl [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  function automatic logic [15:0] model_pix(input int x, input int y,
                                            input logic [1:0] pat, input logic [15:0] solid);
    int g;
    case (pat)
      2'd0: return bar_tbl[x / (H / 8)];
      2'd1: return solid;
      2'd2: return 16'((y % 256) * 256 + (x % 256));
      default: begin
        g = (x % 32) * 2048 + (x % 64) * 32 + (x % 32);
        return 16'(g);
      end
    endcase
  endfunction

  // {vsync, href, d} during PCLK number k of a frame (k = 0 at vsync rise).
  function automatic logic [9:0] exp_sample(input int k, input logic [1:0] pat,
                                            input logic [15:0] solid);
    int kk, line, pos;
    logic [15:0] px;
    if (k < VS) return 10'h200;
    kk = k - VS - VB;
    if (kk < 0) return 10'h000;
    line = kk / LINE_P;
    pos  = kk % LINE_P;
    if (line >= V || pos >= 2 * H) return 10'h000;
    px = model_pix(pos / 2, line, pat, solid);
    return {2'b01, (pos % 2 == 0) ? px[15:8] : px[7:0]};
  endfunction

  logic [7:0] cap [NSLOT][V][2*H];

  // PCLK-edge stability and blanking-data checks on every clk.
  logic [9:0] prev_s;
  logic       prev_ok = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_ok = 1'b0;
    end else begin
      if (cam_bus.cam_pclk && prev_ok)
        check("stable_at_pclk_rise", {cam_bus.cam_vsync, cam_bus.cam_href, cam_bus.cam_d}, prev_s);
      if (!cam_bus.cam_href) check("d_zero_outside_href", cam_bus.cam_d, 0);
      prev_s  = {cam_bus.cam_vsync, cam_bus.cam_href, cam_bus.cam_d};
      prev_ok = 1'b1;
    end
  end

  task automatic run_frame(input int slot, input logic [1:0] pat, input logic [15:0] solid,
                           input logic [1:0] nxt_pat, input logic [15:0] nxt_solid,
                           input int drop_at, output int gap);
    int waited, kk;
    logic [11:0] got;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!cam_bus.cam_vsync && waited < 400);
    gap = waited;
    if (!cam_bus.cam_vsync) begin
      check("vsync_start_timeout", 0, 1);
      return;
    end
    // Next frame's settings change here, mid-frame, and must not leak in.
    pattern   = nxt_pat;
    solid_rgb = nxt_solid;
    for (int k = 0; k < FRAME_S; k++) begin
      if (k > 0) @(negedge clk);
      @(negedge clk);
      if (k == drop_at) enable = 1'b0;
      got = {busy, frame_done, cam_bus.cam_vsync, cam_bus.cam_href, cam_bus.cam_d};
      check($sformatf("frame%0d_pclk%0d", slot, k), got, {2'b10, exp_sample(k, pat, solid)});
      kk = k - VS - VB;
      if (slot < NSLOT && kk >= 0 && kk / LINE_P < V && kk % LINE_P < 2 * H)
        cap[slot][kk / LINE_P][kk % LINE_P] = cam_bus.cam_d;
    end
    @(negedge clk);
    check($sformatf("frame%0d_done_pulse", slot), {frame_done, busy}, 2'b10);
    @(negedge clk);
    check($sformatf("frame%0d_done_width", slot), frame_done, 0);
  endtask

  typedef struct {
    int         slot;
    int         line;
    int         pos;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add_vec(input int slot, input int line, input int pos, input logic [7:0] exp);
    vec_t v;
    v.slot = slot; v.line = line; v.pos = pos; v.exp = exp;
    tbl.push_back(v);
  endtask

  logic [7:0]  bar_bytes [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                  8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
  logic [1:0]  cfg_pat   [8];
  logic [15:0] cfg_solid [8];

  initial begin
    int gap;
    int seen;
    rst = 1'b0; enable = 1'b0; pattern = 2'd2; solid_rgb = 16'h0000;

    for (int x = 0; x < H; x++) begin
      add_vec(0, 2, 2 * x, 8'h02);
      add_vec(0, 2, 2 * x + 1, 8'(x));
    end
    for (int i = 0; i < 16; i++) add_vec(1, 0, i, bar_bytes[i]);
    add_vec(2, 0, 0, 8'h12);  add_vec(2, 0, 1, 8'h34);
    add_vec(2, 3, 14, 8'h12); add_vec(2, 3, 15, 8'h34);
    add_vec(3, 1, 4, 8'hAB);  add_vec(3, 1, 5, 8'hCD);

    cfg_pat[0] = 2'd2; cfg_solid[0] = 16'h0000;
    cfg_pat[1] = 2'd0; cfg_solid[1] = 16'h5555;
    cfg_pat[2] = 2'd1; cfg_solid[2] = 16'h1234;
    cfg_pat[3] = 2'd1; cfg_solid[3] = 16'hABCD;
    for (int i = 4; i < 7; i++) begin
      cfg_pat[i]   = 2'($urandom_range(0, 3));
      cfg_solid[i] = 16'($urandom);
    end
    cfg_pat[7] = 2'd3; cfg_solid[7] = 16'($urandom);

    repeat (3) @(negedge clk);
    check("rst_pclk", cam_bus.cam_pclk, 0);
    check("rst_vsync", cam_bus.cam_vsync, 0);
    check("rst_href", cam_bus.cam_href, 0);
    check("rst_d", cam_bus.cam_d, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) rst = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_no_vsync", cam_bus.cam_vsync, 0);
    check("idle_not_busy", busy, 0);

    pattern = cfg_pat[0]; solid_rgb = cfg_solid[0];
    enable = 1'b1;
    for (int f = 0; f < 7; f++) begin
      run_frame(f, cfg_pat[f], cfg_solid[f], cfg_pat[f + 1], cfg_solid[f + 1],
                (f == 6) ? VS + VB + LINE_P + 5 : -1, gap);
      if (f > 0) check($sformatf("idle_gap_before_frame%0d", f), gap, 1);
    end

    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (cam_bus.cam_vsync || busy) seen++;
    end
    check("idle_after_enable_drop", seen, 0);

    foreach (tbl[i])
      check($sformatf("tbl%0d_slot%0d_line%0d_byte%0d", i, tbl[i].slot, tbl[i].line, tbl[i].pos),
            cap[tbl[i].slot][tbl[i].line][tbl[i].pos], tbl[i].exp);

    // Async reset in the middle of an active line.
    enable = 1'b1;
    seen = 0;
    do begin
      @(negedge clk);
      seen++;
    end while (!cam_bus.cam_vsync && seen < 400);
    repeat (2 * (VS + VB + 3)) @(negedge clk);
    check("pre_reset_in_active", cam_bus.cam_href, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_pclk", cam_bus.cam_pclk, 0);
    check("async_rst_vsync", cam_bus.cam_vsync, 0);
    check("async_rst_href", cam_bus.cam_href, 0);
    check("async_rst_d", cam_bus.cam_d, 0);
    check("async_rst_frame_done", frame_done, 0);
    check("async_rst_busy", busy, 0);
    @(negedge clk) rst = 1'b1;
    run_frame(NSLOT, cfg_pat[7], cfg_solid[7], cfg_pat[7], cfg_solid[7], -1, gap);
    enable = 1'b0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
